// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
package systolic_pkg;

    localparam int N_DEF         = 4;
    localparam int DW_DEF        = 8;
    localparam int KW_DEF        = 8;
    localparam int SKEW_STEP_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_FEED,
        ST_FLUSH,
        ST_DONE
    } state_t;

    // Beats of zero padding needed to drain the deepest skew lane through the
    // far corner PE: output register, A_reg, accumulate, C_out.
    function automatic int flush_len(input int n, input int skew_step);
        return 2 * skew_step * (n - 1) + 4;
    endfunction

endpackage

// File: rtl/skew_line.sv
// Enable-gated shift chain of DEPTH registers; zero select pushes 0 instead of din.
module skew_line #(
    parameter int DEPTH = 1,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          zero,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < DEPTH; s++) stage[s] <= '0;
        end else if (en) begin
            stage[0] <= zero ? '0 : din;
            for (int s = 1; s < DEPTH; s++) stage[s] <= stage[s-1];
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/systolic_feeder.sv
// Tile sequencer and per-lane skew for the west/north edges of an NxN PE array.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; array idle
// ST_CLR   | one cycle of accumulator clear
// ST_FEED  | accepting K slices; array advances only on handshake
// ST_FLUSH | pushing zeros until the far corner PE has its final C_out
// ST_DONE  | one-cycle done pulse, busy drops on the following edge
module systolic_feeder
    import systolic_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int DW        = DW_DEF,
    parameter int KW        = KW_DEF,
    parameter int SKEW_STEP = SKEW_STEP_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [KW-1:0] k_len,
    output logic          busy,
    output logic          done,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N*DW-1:0] in_a,
    input  logic [N*DW-1:0] in_b,
    output logic          arr_en,
    output logic          arr_rst_n,
    output logic [N*DW-1:0] a_edge,
    output logic [N*DW-1:0] b_edge
);

    localparam int FLUSH_LEN = flush_len(N, SKEW_STEP);
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    state_t        state;
    logic [KW-1:0] k_lat;
    logic [KW-1:0] slice_cnt;
    logic [FW-1:0] flush_cnt;
    logic          zero_push;

    // arr_en must follow in_valid in the same cycle so a stall freezes the
    // whole array and the skew chains together.
    assign arr_en    = (in_ready && in_valid) || (state == ST_FLUSH);
    assign zero_push = (state == ST_FLUSH);
    assign arr_rst_n = rst_n && (state != ST_CLR);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            k_lat     <= '0;
            slice_cnt <= '0;
            flush_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            in_ready  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        k_lat <= k_len;
                        busy  <= 1'b1;
                        state <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    slice_cnt <= '0;
                    flush_cnt <= '0;
                    if (k_lat == '0) begin
                        state <= ST_FLUSH;
                    end else begin
                        state    <= ST_FEED;
                        in_ready <= 1'b1;
                    end
                end
                ST_FEED: begin
                    if (in_valid) begin
                        if (slice_cnt == k_lat - KW'(1)) begin
                            state    <= ST_FLUSH;
                            in_ready <= 1'b0;
                        end else begin
                            slice_cnt <= slice_cnt + KW'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FW'(FLUSH_LEN - 1)) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FW'(1);
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Lane i is delayed SKEW_STEP*i beats beyond the common output register.
    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_line #(
            .DEPTH (SKEW_STEP * i + 1),
            .DW    (DW)
        ) u_skew_a (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (arr_en),
            .zero  (zero_push),
            .din   (in_a[i*DW +: DW]),
            .dout  (a_edge[i*DW +: DW])
        );

        skew_line #(
            .DEPTH (SKEW_STEP * i + 1),
            .DW    (DW)
        ) u_skew_b (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (arr_en),
            .zero  (zero_push),
            .din   (in_b[i*DW +: DW]),
            .dout  (b_edge[i*DW +: DW])
        );
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Self-checking bench: feeder driving a behavioural NxN PE array, results scoreboarded.
`timescale 1ns/1ps
module tb_systolic_feeder;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int KW        = 8;
    localparam int SKEW      = 2;
    localparam int FLUSH_LEN = 2 * SKEW * (N - 1) + 4;
    localparam int MAXK      = 8;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          done;
    logic          in_valid;
    logic          in_ready;
    logic [N*DW-1:0] in_a;
    logic [N*DW-1:0] in_b;
    logic          arr_en;
    logic          arr_rst_n;
    logic [N*DW-1:0] a_edge;
    logic [N*DW-1:0] b_edge;

    systolic_feeder #(.N(N), .DW(DW), .KW(KW), .SKEW_STEP(SKEW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .k_len     (k_len),
        .busy      (busy),
        .done      (done),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .arr_en    (arr_en),
        .arr_rst_n (arr_rst_n),
        .a_edge    (a_edge),
        .b_edge    (b_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural PE array: 2-beat forwarding, accumulate on A_reg*B_reg, C_out one beat later.
    logic [DW-1:0] a_in [N][N];
    logic [DW-1:0] b_in [N][N];
    logic [DW-1:0] pa_r [N][N];
    logic [DW-1:0] pa_o [N][N];
    logic [DW-1:0] pb_r [N][N];
    logic [DW-1:0] pb_o [N][N];
    logic [31:0]   acc  [N][N];
    logic [31:0]   c_out[N][N];

    always_comb begin
        a_in = '{default: '0};
        b_in = '{default: '0};
        for (int i = 0; i < N; i++) begin
            a_in[i][0] = a_edge[i*DW +: DW];
            for (int j = 1; j < N; j++) a_in[i][j] = pa_o[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            b_in[0][j] = b_edge[j*DW +: DW];
            for (int i = 1; i < N; i++) b_in[i][j] = pb_o[i-1][j];
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (!arr_rst_n) begin
                    pa_r[i][j]  <= '0;
                    pa_o[i][j]  <= '0;
                    pb_r[i][j]  <= '0;
                    pb_o[i][j]  <= '0;
                    acc[i][j]   <= '0;
                    c_out[i][j] <= '0;
                end else if (arr_en) begin
                    pa_r[i][j]  <= a_in[i][j];
                    pa_o[i][j]  <= pa_r[i][j];
                    pb_r[i][j]  <= b_in[i][j];
                    pb_o[i][j]  <= pb_r[i][j];
                    acc[i][j]   <= acc[i][j] + 32'(pa_r[i][j]) * 32'(pb_r[i][j]);
                    c_out[i][j] <= acc[i][j];
                end
            end
        end
    end

    logic [31:0] sb_q[$];
    int done_cnt   = 0;
    int rstlow_cnt = 0;

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (sb_q.size() < N * N) begin
                check_val("done_unexpected", 32'd1, 32'd0);
            end else begin
                for (int i = 0; i < N; i++)
                    for (int j = 0; j < N; j++)
                        check_val("c_out", c_out[i][j], sb_q.pop_front());
            end
        end
        if (rst_n && arr_rst_n === 1'b0) rstlow_cnt++;
    end

    logic [DW-1:0] ta [N][MAXK];
    logic [DW-1:0] tbm[MAXK][N];

    task automatic fill_random(input int k);
        for (int kk = 0; kk < k; kk++)
            for (int i = 0; i < N; i++) begin
                ta[i][kk]  = 8'($urandom_range(0, 255));
                tbm[kk][i] = 8'($urandom_range(0, 255));
            end
    endtask

    task automatic run_tile(input int k, input logic [7:0] stall_mask, input int exp_stalls,
                            input bit mid_start, input bit watch_edges);
        logic [31:0] s;
        int idx, f, guard, n, stalls, beats, t_start, t_acc, d;
        bit acc_now, got_done;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                s = '0;
                for (int kk = 0; kk < k; kk++) s += 32'(ta[i][kk]) * 32'(tbm[kk][j]);
                sb_q.push_back(s);
            end
        rstlow_cnt = 0;
        start = 1'b1;
        k_len = 8'(k);
        @(negedge clk);
        t_start = cyc;
        tick();
        start = 1'b0;
        idx = 0; f = 0; guard = 0; stalls = 0; t_acc = t_start;
        while (idx < k && guard < 200) begin
            if (in_ready && f < 8 && stall_mask[f]) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                for (int i = 0; i < N; i++) begin
                    in_a[i*DW +: DW] = ta[i][idx];
                    in_b[i*DW +: DW] = tbm[idx][i];
                end
            end
            if (mid_start && in_ready) begin
                start = 1'b1;
                k_len = '0;
            end
            @(negedge clk);
            acc_now = in_valid && in_ready;
            if (in_ready) begin
                check_val("arr_en_feed", arr_en, in_valid);
                check_val("busy_feed", busy, 1);
                f++;
                if (!in_valid) stalls++;
            end else begin
                check_val("arr_en_not_ready", arr_en, 0);
            end
            if (acc_now) t_acc = cyc;
            tick();
            start = 1'b0;
            if (acc_now) idx++;
            guard++;
        end
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        if (guard >= 200) check_val("feed_timeout", idx, k);
        check_val("stall_count", stalls, exp_stalls);
        got_done = 1'b0; n = 0; beats = 0;
        while (!got_done && n < 60) begin
            @(negedge clk);
            n++;
            if (watch_edges) begin
                d = cyc - t_acc;
                if (d >= 1 && d <= FLUSH_LEN)
                    for (int i = 0; i < N; i++) begin
                        check_val("a_edge_lane", a_edge[i*DW +: DW], (d == SKEW * i + 1) ? ta[i][0] : 0);
                        check_val("b_edge_lane", b_edge[i*DW +: DW], (d == SKEW * i + 1) ? tbm[0][i] : 0);
                    end
            end
            if (done === 1'b1) begin
                got_done = 1'b1;
                check_val("arr_en_done", arr_en, 0);
                check_val("busy_at_done", busy, 1);
                check_val("lat_start", cyc - t_start, k + stalls + FLUSH_LEN + 2);
                if (k > 0) check_val("lat_last_slice", cyc - t_acc, FLUSH_LEN + 1);
            end else if (arr_en === 1'b1) begin
                beats++;
            end
        end
        check_val("done_seen", got_done, 1);
        check_val("flush_beats", beats, FLUSH_LEN);
        check_val("clr_cycles", rstlow_cnt, 1);
        tick();
        @(negedge clk);
        check_val("busy_after_done", busy, 0);
        check_val("done_one_cycle", done, 0);
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int n, d0;

    initial begin
        rst_n = 1'b0; start = 1'b0; k_len = '0;
        in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_arr_en", arr_en, 0);
        check_val("rst_arr_rst_n", arr_rst_n, 0);
        check_val("rst_a_edge", a_edge, 0);
        check_val("rst_b_edge", b_edge, 0);
        tick();
        rst_n = 1'b1;
        tick();
        @(negedge clk);
        check_val("idle_arr_rst_n", arr_rst_n, 1);
        check_val("idle_in_ready", in_ready, 0);
        tick();

        // k=1, A all 1, B all 2: every C_out is 2
        for (int i = 0; i < N; i++) begin
            ta[i][0]  = 8'd1;
            tbm[0][i] = 8'd2;
        end
        run_tile(1, 8'h00, 0, 1'b0, 1'b0);

        // k=3 random, then the same data with 5 stalls
        fill_random(3);
        run_tile(3, 8'h00, 0, 1'b0, 1'b0);
        run_tile(3, 8'b0110_1101, 5, 1'b0, 1'b0);

        // single slice, observe the skew on each lane
        for (int i = 0; i < N; i++) begin
            ta[i][0]  = 8'(i + 1);
            tbm[0][i] = 8'(16 + 3 * i);
        end
        run_tile(1, 8'h00, 0, 1'b0, 1'b1);

        // start pulsed during FEED is ignored, then an empty tile
        fill_random(3);
        run_tile(3, 8'h00, 0, 1'b1, 1'b0);
        run_tile(0, 8'h00, 0, 1'b0, 1'b0);

        // reset for one edge in the middle of FEED
        fill_random(3);
        start = 1'b1;
        k_len = 8'd3;
        tick();
        start = 1'b0;
        n = 0;
        while (!in_ready && n < 5) begin
            tick();
            n++;
        end
        check_val("reach_feed", in_ready, 1);
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_a[i*DW +: DW] = ta[i][0];
            in_b[i*DW +: DW] = tbm[0][i];
        end
        tick();
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_val("arr_rst_in_reset", arr_rst_n, 0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_in_ready", in_ready, 0);
        check_val("post_rst_arr_en", arr_en, 0);
        check_val("post_rst_a_edge", a_edge, 0);
        check_val("post_rst_b_edge", b_edge, 0);
        check_val("post_rst_done", done, 0);
        d0 = done_cnt;
        repeat (30) tick();
        check_val("no_done_after_reset", done_cnt, d0);

        fill_random(2);
        run_tile(2, 8'h00, 0, 1'b0, 1'b0);

        check_val("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
